nand_chain_seq: RTL

Sequencer that evaluates the cascaded-NAND chain (tap0 = ~(x0&x1), tapk = ~(tap(k-1)&x(k+1))) serially through one shared 2-input NAND stage, one stage per clock. It sits between a requester presenting an N-bit operand word and a consumer of the N-1 chain taps. Both sides use a valid/ready handshake. It replaces the flat combinational chain wherever gate count matters more than latency.

---
 rtl/nand_chain_seq_pkg.sv | 13 +
 rtl/nand_chain_seq_if.sv | 29 ++
 rtl/nand_chain_seq_stage.sv | 11 +
 rtl/nand_chain_seq.sv | 137 +++++++++++++
 4 files changed

// File: rtl/nand_chain_seq_pkg.sv
// nand_chain_seq_pkg: shared types and constants for the serial NAND-chain sequencer.
// Holds the FSM state encoding and the default operand width.
package nand_seq_pkg;

    localparam int NAND_SEQ_N_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EVAL = 2'd1,
        DONE = 2'd2
    } nand_seq_state_t;

endpackage

// File: rtl/nand_chain_seq_if.sv
// nand_chain_seq_if: operand/tap handshake bundle for nand_chain_seq.
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both high; the sender holds its payload stable while valid is high and ready
// is low. The master drives in_valid/x/out_ready; the slave (the sequencer)
// drives in_ready/out_valid/y/busy and exposes its FSM state on dbg_state.
import nand_seq_pkg::*;

interface nand_chain_seq_if #(
    parameter int N = NAND_SEQ_N_DEF
);
    logic            in_valid;
    logic            in_ready;
    logic [N-1:0]    x;
    logic            out_valid;
    logic            out_ready;
    logic [N-2:0]    y;
    logic            busy;
    nand_seq_state_t dbg_state;

    modport master (
        output in_valid, x, out_ready,
        input  in_ready, out_valid, y, busy, dbg_state
    );

    modport slave (
        input  in_valid, x, out_ready,
        output in_ready, out_valid, y, busy, dbg_state
    );
endinterface

// File: rtl/nand_chain_seq_stage.sv
// nand_stage: the one shared 2-input NAND that the sequencer reuses every
// evaluation cycle. Inputs are the running accumulator and the selected
// operand bit; the output is the next chain tap.
module nand_stage (
    input  logic acc,
    input  logic xr_bit,
    output logic tap
);
    // Single NAND gate producing the next tap.
    assign tap = ~(acc & xr_bit);
endmodule

// File: rtl/nand_chain_seq.sv
// nand_chain_seq: evaluates the cascaded NAND chain
//   tap0 = ~(x0 & x1), tapk = ~(tap(k-1) & x(k+1))
// one stage per clock through a single shared NAND gate.
// Optional macro NAND_SEQ_CHECK_EN adds an err output that compares the serial
// result against an inline combinational golden chain on entry to DONE.
import nand_seq_pkg::*;

module nand_chain_seq #(
    parameter int N = NAND_SEQ_N_DEF
) (
    input  logic                clk,
    input  logic                rst,
    nand_chain_seq_if.slave     bus
`ifdef NAND_SEQ_CHECK_EN
    ,
    output logic                err
`endif
);
    // idx only has to reach N-1, so clog2(N) bits suffice; keep at least one bit.
    localparam int IDX_W = (N > 2) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

    nand_seq_state_t  state_q, state_d;
    logic [N-1:0]     xr_q, xr_d;
    logic             acc_q, acc_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [N-2:0]     y_q, y_d;
    logic [IDX_W-1:0] tap_pos;
    logic             tap;

    // Tap k lands in y[k]; idx runs one ahead of the tap it produces.
    assign tap_pos = idx_q - 1'b1;

    nand_stage u_stage (
        .acc    (acc_q),
        .xr_bit (xr_q[idx_q]),
        .tap    (tap)
    );

    // Next-state and datapath update for the IDLE/EVAL/DONE sequencer.
    always_comb begin
        state_d = state_q;
        xr_d    = xr_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    xr_d    = bus.x;
                    acc_d   = bus.x[0];
                    idx_d   = IDX_W'(1);
                    y_d     = '0;
                    state_d = EVAL;
                end
            end
            EVAL: begin
                acc_d        = tap;
                y_d[tap_pos] = tap;
                // Hold idx on the exit edge so it never wraps.
                if (idx_q == IDX_LAST) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            xr_q    <= '0;
            acc_q   <= 1'b0;
            idx_q   <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            xr_q    <= xr_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            y_q     <= y_d;
        end
    end

    // Handshake outputs decode from the state register only.
    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.y         = y_q;
    assign bus.dbg_state = state_q;

`ifdef NAND_SEQ_CHECK_EN
    logic [N-2:0] gold;
    logic         err_q, err_d;

    // Flat reference chain over the captured operand.
    always_comb begin
        logic c;
        gold = '0;
        c    = xr_q[0];
        for (int k = 1; k < N; k++) begin
            c         = ~(c & xr_q[k]);
            gold[k-1] = c;
        end
    end

    // Latch the compare as DONE is entered; clear when leaving DONE.
    always_comb begin
        err_d = err_q;
        if (state_q == EVAL && idx_q == IDX_LAST) begin
            err_d = (gold != y_d);
        end else if (state_q == DONE && bus.out_ready) begin
            err_d = 1'b0;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

endmodule
